// File: rtl/tri_scan_ring_ctl.sv
// Scan-ring sequencer: serially loads a config word into a latch ring while
// capturing the prior ring contents, and drives the LCB thold_b/force_t controls.
module tri_scan_ring_ctl #(
    parameter int   RING_LEN   = 16,
    parameter int   CNT_WIDTH  = 6,
    parameter logic THOLD_INIT = 1'b1
) (
    input  logic                nclk,
    input  logic                sreset_b,
    input  logic                req_val,
    output logic                req_rdy,
    input  logic [0:RING_LEN-1] req_data,
    output logic                scan_out,
    input  logic                scan_in,
    output logic                thold_b,
    output logic                force_t,
    output logic                busy,
    output logic                done_val,
    output logic [0:RING_LEN-1] done_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(RING_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q,     state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;
    logic [0:RING_LEN-1]   shadow_q,    shadow_d;
    logic [0:RING_LEN-1]   capture_q,   capture_d;
    logic [0:RING_LEN-1]   done_data_q, done_data_d;

    // State register and datapath registers with synchronous active-low reset.
    always_ff @(posedge nclk) begin
        if (!sreset_b) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_WIDTH{1'b0}};
            shadow_q    <= {RING_LEN{1'b0}};
            capture_q   <= {RING_LEN{1'b0}};
            done_data_q <= {RING_LEN{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            capture_q   <= capture_d;
            done_data_q <= done_data_d;
        end
    end

    // Next-state and datapath update; the shadow drains from its high index
    // while returning ring bits enter at the high end of the capture register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        capture_d   = capture_q;
        done_data_d = done_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_val) begin
                    shadow_d = req_data;
                    cnt_d    = {CNT_WIDTH{1'b0}};
                    state_d  = ST_SETUP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shadow_d  = {1'b0, shadow_q[0:RING_LEN-2]};
                capture_d = {capture_q[1:RING_LEN-1], scan_in};
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DRAIN: begin
                done_data_d = capture_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from state and registers only; force_t is confined to
    // SHIFT where thold_b is low, so the two are never active together.
    always_comb begin
        req_rdy   = 1'b0;
        busy      = 1'b1;
        done_val  = 1'b0;
        scan_out  = 1'b0;
        thold_b   = 1'b0;
        force_t   = 1'b0;
        done_data = done_data_q;
        case (state_q)
            ST_IDLE: begin
                req_rdy = 1'b1;
                busy    = 1'b0;
                thold_b = THOLD_INIT;
            end
            ST_SETUP: begin
                thold_b = 1'b0;
            end
            ST_SHIFT: begin
                force_t  = 1'b1;
                scan_out = shadow_q[RING_LEN-1];
            end
            ST_DRAIN: begin
                thold_b = 1'b0;
            end
            ST_DONE: begin
                thold_b  = THOLD_INIT;
                done_val = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/tri_scan_ring_ctl.md
Name: tri_scan_ring_ctl

Overview:
- Scan-ring sequencer upstream of a chain of scan-only latch banks.
- Accepts a parallel configuration word and drives it serially onto the ring's scan input. Generates the `thold_b` / `force_t` controls the LCB-based latch banks consume.
- Captures the serial data returning from the ring, so software gets the previous ring contents back (exchange operation).
- Used for boot-time and debug config loading of mode/init latches.

Parameters:
- RING_LEN, 16, number of latch bits in the ring; valid range 2..64.
- CNT_WIDTH, 6, shift-counter width; must satisfy 2**CNT_WIDTH > RING_LEN.
- THOLD_INIT, 1'b1, value of `thold_b` in IDLE and after reset (1 = functional clocking).

Ports:
- nclk  in  1  clock; all state updates on rising edge.
- sreset_b  in  1  reset, synchronous, active-low.
- req_val  in  1  request valid.
- req_rdy  out  1  ready; request accepted on `req_val & req_rdy`.
- req_data  in  [0:RING_LEN-1]  word to load into ring.
- scan_out  out  1  serial data to ring scan input.
- scan_in  in  1  serial data returning from ring scan output.
- thold_b  out  1  to ring LCBs; 0 = functional clock held.
- force_t  out  1  to ring LCBs; 1 = force LCB active for scan shifting.
- busy  out  1  state != IDLE.
- done_val  out  1  one-cycle completion pulse.
- done_data  out  [0:RING_LEN-1]  prior ring contents captured during shift.

Behaviour:
- Reset (`sreset_b = 0` at a clock edge) has priority over everything:
  - state = IDLE; counter = 0; shadow and capture registers = 0.
  - Outputs: `req_rdy = 1`, `busy = 0`, `done_val = 0`, `done_data = 0`, `scan_out = 0`, `thold_b = THOLD_INIT`, `force_t = 0`.
  - Reset mid-operation aborts immediately. Ring contents are then undefined; no `done_val` is issued.
- States: IDLE, SETUP, SHIFT, DRAIN, DONE. All outputs are registered or decoded from state plus registers; there are no combinational paths from inputs to outputs.
- IDLE:
  - `req_rdy = 1`.
  - On `req_val`: shadow <= `req_data`, counter <= 0, go to SETUP. Otherwise remain.
- SETUP (1 cycle): `thold_b = 0`, `force_t = 0`. Next state is SHIFT.
- SHIFT (exactly RING_LEN cycles):
  - `thold_b = 0`, `force_t = 1`.
  - `scan_out` = shadow[RING_LEN-1]. Each cycle shadow shifts toward higher index, with bit 0 filled with 0.
  - Bit RING_LEN-1 leaves first; after RING_LEN shifts, ring position 0 holds `req_data[0]`.
  - Each SHIFT cycle: capture <= {capture[1:RING_LEN-1], scan_in}. The first bit returned ends in capture[0].
  - Counter increments each cycle. When counter == RING_LEN-1, go to DRAIN.
- DRAIN (1 cycle): `force_t = 0`, `thold_b = 0`, `scan_out = 0`. Next state is DONE.
- DONE (1 cycle):
  - `thold_b = THOLD_INIT`.
  - `done_val = 1`; `done_data` = capture, held stable until the next DONE.
  - Next state is IDLE.
- Latency: accept at edge T. SETUP is cycle T+1, SHIFT is T+2..T+1+RING_LEN, DRAIN is T+2+RING_LEN, `done_val` is at T+3+RING_LEN. Next accept is possible at T+4+RING_LEN.
- `req_rdy = 0` in every non-IDLE state. `req_val` while not ready is ignored: no queuing, and `req_data` is not sampled.
- `req_data` changing after acceptance has no effect.
- `force_t = 1` and `thold_b = 1` are never asserted together.
- `scan_out = 0` whenever not in SHIFT.
- `scan_in` is ignored outside SHIFT.

Test Plan:
- Reset check: hold `sreset_b = 0` for 3 cycles, then release -> `req_rdy = 1`, `busy = 0`, `thold_b = 1`, `force_t = 0`, `done_val = 0`, `done_data = 0`.
- Single load (RING_LEN=4): `req_data = 4'b1011` accepted at T -> `scan_out` over T+2..T+5 = 1,1,0,1; `force_t = 1` exactly those 4 cycles; `done_val` only at T+7.
- Exchange (RING_LEN=4): `scan_in` = 0,1,1,0 over T+2..T+5 -> `done_data = 4'b0110`. Then a loop-back model of a 4-bit ring returns the previously loaded word on the next request.
- Backpressure: `req_val` held high continuously with changing data -> second accept occurs exactly at T+8 using data sampled at T+8; no request is lost or duplicated.
- Reset mid-SHIFT: `sreset_b = 0` at T+3 -> next cycle IDLE, `thold_b = 1`, `force_t = 0`; `done_val` never pulses for the aborted request.
- Max length (RING_LEN=64, CNT_WIDTH=7): all-ones load -> exactly 64 SHIFT cycles with `scan_out = 1`; counter does not wrap; `done_val` at T+67.
